fmap_window_fetcher: RTL and testbench

FMAP_WINDOW_FETCHER -- requirements
Module: fmap_window_fetcher

---
 rtl/fmap_pkg.sv | 7 +
 rtl/win_fifo.sv | 42 ++++
 rtl/fmap_window_fetcher.sv | 83 ++++++++
 tb/tb_fmap_window_fetcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// fmap_pkg: shared widths and latencies for the fmap window fetch path
package fmap_pkg;
  localparam int FMAP_DATA_W  = 16;
  localparam int FMAP_WIN_LEN = 3;
  localparam int FMAP_RD_LAT  = 1;
  localparam int FMAP_CNT_W   = 16;
endpackage

// File: rtl/win_fifo.sv
// win_fifo: synchronous window buffer; push into a full FIFO succeeds only alongside a pop
module win_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty   = wr_q == rd_q;
  assign full    = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    wr_d = clr ? '0 : wr_q + PW'(do_push);
    rd_d = clr ? '0 : rd_q + PW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fmap_window_fetcher.sv
// fmap_window_fetcher: issues BRAM reads per address and packs WIN_LEN words into buffered windows
module fmap_window_fetcher
  import fmap_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = FMAP_DATA_W,
  parameter int WIN_LEN    = FMAP_WIN_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         in_address,
  input  logic                          in_valid,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic [WIN_LEN*DATA_WIDTH-1:0] win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [FMAP_CNT_W-1:0]         win_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int IW = WIN_LEN > 1 ? $clog2(WIN_LEN) : 1;
  logic bram_en_q, bram_en_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIN_LEN-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d, win_w;
  logic [FMAP_CNT_W-1:0] cnt_q, cnt_d;
  logic cap, last, push, pop, full, empty;
  assign cap  = pend_q & ~start;
  assign last = idx_q == IW'(WIN_LEN - 1);
  assign push = cap & last;
  assign pop  = win_valid & win_ready;
  // The completing word goes straight into the pushed window, not via lanes_q
  always_comb begin
    bram_en_d   = in_valid & ~start;
    bram_addr_d = bram_en_d ? in_address : bram_addr_q;
    pend_d      = bram_en_q & ~start;
    win_w       = lanes_q;
    win_w[idx_q] = bram_rdata;
    lanes_d     = cap ? win_w : lanes_q;
    idx_d       = start ? '0 : cap ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    cnt_d       = start ? '0 : cnt_q + FMAP_CNT_W'(pop);
    ovf_d       = ~start & (ovf_q | (push & full & ~pop));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      pend_q      <= 1'b0;
      idx_q       <= '0;
      lanes_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  win_fifo #(.W(WIN_LEN*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (push),
    .pop   (pop),
    .din   (win_w),
    .dout  (win_data),
    .full  (full),
    .empty (empty)
  );
  assign win_valid = ~empty;
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign win_count = cnt_q;
  assign overflow  = ovf_q;
  assign busy      = bram_en_q | pend_q | (idx_q != '0) | ~empty;
endmodule

// File: tb/tb_fmap_window_fetcher.sv
// tb_fmap_window_fetcher: randomized scoreboard bench; windows predicted from address triples
module tb_fmap_window_fetcher;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, win_ready = 0;
  logic [31:0] in_address = 0, bram_addr;
  logic [15:0] bram_rdata = 0, win_count;
  logic [47:0] win_data;
  logic bram_en, win_valid, overflow, busy;
  int checks = 0, errors = 0, cyc = 0, first_vld = -1, t3 = 0;
  bit rnd_ready = 0;
  logic [47:0] sb[$];
  logic [31:0] part[$];

  fmap_window_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .in_address(in_address), .in_valid(in_valid),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_count(win_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // BRAM model: word at address a holds a[15:0]; garbage when not enabled
  always @(posedge clk) bram_rdata <= bram_en ? bram_addr[15:0] : 16'($urandom);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && win_valid) begin
      if (first_vld < 0) first_vld = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got %0h expected none", win_data);
      end else begin
        chk("win_data", {16'h0, win_data}, {16'h0, sb[0]});
        if (win_ready) void'(sb.pop_front());
      end
    end

  task automatic model(input logic [31:0] a, input bit keep);
    part.push_back(a);
    if (part.size() == 3) begin
      if (keep) sb.push_back({part[2][15:0], part[1][15:0], part[0][15:0]});
      part.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 0;
    if (rnd_ready) win_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic issue(input logic [31:0] a, input bit keep = 1);
    step();
    in_valid = 1;
    in_address = a;
    model(a, keep);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end
  endtask

  task automatic do_start();
    step();
    start = 1;
    in_valid = 1;
    in_address = 32'h0000_DEAD;
    sb.delete();
    part.delete();
    step();
    start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_count", win_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 0;
    // spaced reads, start-cycle in_valid must be ignored
    do_start();
    win_ready = 1;
    issue(32'h100); idle(3);
    issue(32'h101); idle(3);
    issue(32'h102);
    drain("spaced");
    chk("spaced_count", win_count, 1);
    chk("spaced_overflow", overflow, 0);
    chk("spaced_busy", busy, 0);
    // back-to-back and first-valid latency
    do_start();
    first_vld = -1;
    for (int i = 0; i < 6; i++) begin
      issue(i);
      if (i == 2) t3 = cyc;
    end
    drain("b2b");
    chk("b2b_latency", first_vld, t3 + 3);
    chk("b2b_count", win_count, 2);
    // overflow with stalled consumer
    do_start();
    win_ready = 0;
    for (int i = 0; i < 15; i++) issue(32'h400 + i, i < 12);
    idle(8);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_stalled", win_count, 0);
    chk("ovf_valid_stalled", win_valid, 1);
    win_ready = 1;
    drain("ovf");
    chk("ovf_count", win_count, 4);
    chk("ovf_sticky", overflow, 1);
    // push into full FIFO while popping
    do_start();
    chk("start_clears_ovf", overflow, 0);
    win_ready = 0;
    for (int i = 0; i < 15; i++) issue(32'h500 + i);
    step();
    step();
    win_ready = 1;
    step();
    win_ready = 0;
    chk("full_pp_count", win_count, 1);
    chk("full_pp_overflow", overflow, 0);
    idle(3);
    chk("full_pp_valid", win_valid, 1);
    win_ready = 1;
    drain("full_pp");
    chk("full_pp_total", win_count, 5);
    chk("full_pp_no_ovf", overflow, 0);
    // reset mid-window with a read in flight
    do_start();
    issue(32'h300);
    issue(32'h301);
    step();
    #1 rst = 1;
    sb.delete();
    part.delete();
    #1;
    chk("mid_rst_bram_en", bram_en, 0);
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", win_count, 0);
    step();
    rst = 0;
    issue(32'h200);
    issue(32'h201);
    issue(32'h202);
    drain("post_rst");
    chk("post_rst_count", win_count, 1);
    chk("post_rst_overflow", overflow, 0);
    // partial window held indefinitely
    issue(32'h600);
    issue(32'h601);
    idle(20);
    chk("partial_no_valid", win_valid, 0);
    chk("partial_busy", busy, 1);
    issue(32'h602);
    drain("partial");
    chk("partial_count", win_count, 2);
    // full-size run with random consumer
    do_start();
    rnd_ready = 1;
    for (int w = 0; w < 12288; w++)
      for (int l = 0; l < 3; l++) begin
        if (l == 2) begin
          int k = 0;
          while (sb.size() >= 4 && k < 1000) begin
            step();
            k++;
          end
        end
        if ($urandom_range(0, 7) == 0) step();
        issue($urandom);
      end
    drain("run");
    chk("run_count", win_count, 12288);
    chk("run_overflow", overflow, 0);
    chk("run_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
